// File: rtl/calc_pkg.sv
// calc_pkg: key codes, entry FSM states and operator encodings for the calculator entry path
package calc_pkg;
  localparam logic [4:0] K_ADD = 5'd10;
  localparam logic [4:0] K_SUB = 5'd11;
  localparam logic [4:0] K_MUL = 5'd12;
  localparam logic [4:0] K_DIV = 5'd13;
  localparam logic [4:0] K_EQ  = 5'd14;
  localparam logic [4:0] K_CLR = 5'd15;
  typedef enum logic [1:0] {S_A, S_B, S_SHOW, S_ERR} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;
  function automatic op_t key_op(input logic [4:0] k);
    return op_t'(k[1:0] - 2'd2);
  endfunction
endpackage

// File: rtl/calc_dec_accum.sv
// calc_dec_accum: decimal digit accumulator with digit-count and range rejection
module calc_dec_accum #(
  parameter int W = 8,
  parameter int MAX_DIGITS = 3,
  localparam int CW = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  input  logic [CW-1:0] load_cnt,
  input  logic          dig_en,
  input  logic [3:0]    dig,
  output logic [W-1:0]  value,
  output logic [CW-1:0] count,
  output logic          rej
);
  logic [W-1:0] val_q, val_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W+3:0] nxt;
  logic take;
  assign nxt = {4'b0, val_q} * (W+4)'(10) + (W+4)'(dig);
  assign rej = dig_en & ((cnt_q == CW'(MAX_DIGITS)) | (nxt > {4'b0, {W{1'b1}}}));
  assign take = dig_en & ~rej;
  assign value = val_q;
  assign count = cnt_q;
  always_comb begin
    val_d = clr ? '0 : load ? load_val : take ? nxt[W-1:0] : val_q;
    cnt_d = clr ? '0 : load ? load_cnt : take ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad entry sequencer producing operands and op select; CALC_CHAIN_EN enables result chaining via res_in
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int W = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [4:0]   key_code,
  output logic         key_ready,
  output logic         key_rej,
  output logic [W-1:0] operand_a,
  output logic [W-1:0] operand_b,
  output logic         sel_a,
  output logic         sel_b,
  output logic         sel_c,
  output logic         sel_d,
  output logic         go,
  output logic         err
`ifdef CALC_CHAIN_EN
  ,
  input  logic [W-1:0] res_in
`endif
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  state_t state_q, state_d;
  op_t op_q, op_d;
  logic go_q, go_d, rej_q, rej_d;
  logic a_clr, a_load, a_dig, a_rej, b_clr, b_dig, b_rej;
  logic [W-1:0] a_load_val;
  logic [CW-1:0] a_load_cnt, b_cnt, unused_a_cnt;
  logic acc, is_dig, is_op, is_eq, is_clr, show;
  assign key_ready = ~rst & ~go_q;
  assign acc = key_valid & key_ready;
  assign is_dig = key_code < 5'd10;
  assign is_op = key_code >= K_ADD && key_code <= K_DIV;
  assign is_eq = key_code == K_EQ;
  assign is_clr = key_code == K_CLR;
  assign show = state_q == S_SHOW;
  assign sel_a = show & (op_q == OP_ADD);
  assign sel_b = show & (op_q == OP_SUB);
  assign sel_c = show & (op_q == OP_DIV);
  assign sel_d = show & (op_q == OP_MUL);
  assign go = go_q;
  assign key_rej = rej_q;
  assign err = state_q == S_ERR;
  calc_dec_accum #(.W(W), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
    .clk(clk), .rst(rst), .clr(a_clr), .load(a_load), .load_val(a_load_val),
    .load_cnt(a_load_cnt), .dig_en(a_dig), .dig(key_code[3:0]),
    .value(operand_a), .count(unused_a_cnt), .rej(a_rej)
  );
  calc_dec_accum #(.W(W), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
    .clk(clk), .rst(rst), .clr(b_clr), .load(1'b0), .load_val('0),
    .load_cnt('0), .dig_en(b_dig), .dig(key_code[3:0]),
    .value(operand_b), .count(b_cnt), .rej(b_rej)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    go_d = 1'b0;
    rej_d = 1'b0;
    a_clr = 1'b0;
    a_load = 1'b0;
    a_load_val = '0;
    a_load_cnt = '0;
    a_dig = 1'b0;
    b_clr = 1'b0;
    b_dig = 1'b0;
    if (acc && is_clr) begin
      state_d = S_A;
      op_d = OP_ADD;
      a_clr = 1'b1;
      b_clr = 1'b1;
    end else if (acc) begin
      unique case (state_q)
        S_A: begin
          a_dig = is_dig;
          rej_d = a_rej;
          if (is_op) begin
            op_d = key_op(key_code);
            b_clr = 1'b1;
            state_d = S_B;
          end
        end
        S_B: begin
          b_dig = is_dig;
          rej_d = b_rej;
          if (is_op && b_cnt == '0) op_d = key_op(key_code);
          if (is_eq && b_cnt != '0) begin
            go_d = !(op_q == OP_DIV && operand_b == '0);
            state_d = go_d ? S_SHOW : S_ERR;
          end
        end
        S_SHOW: begin
          if (is_dig) begin
            a_load = 1'b1;
            a_load_val = W'(key_code[3:0]);
            a_load_cnt = CW'(1);
            b_clr = 1'b1;
            state_d = S_A;
          end
`ifdef CALC_CHAIN_EN
          else if (is_op) begin
            a_load = 1'b1;
            a_load_val = res_in;
            a_load_cnt = CW'(MAX_DIGITS);
            op_d = key_op(key_code);
            b_clr = 1'b1;
            state_d = S_B;
          end
`endif
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_A;
      op_q <= OP_ADD;
      go_q <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      go_q <= go_d;
      rej_q <= rej_d;
    end
  end
endmodule
